// File: rtl/down_counter_load.sv
// rtl/down_counter_load.sv - modulo-N down counter with parallel load, terminal-count pulse and one-shot mode
module down_counter_load #(
   parameter int W   = 4,
   parameter int MOD = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         oneshot,
   output logic [W-1:0] out,
   output logic         tc,
   output logic         zero,
   output logic         busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [W-1:0] MAX_VAL = W'(MOD - 1);
   localparam logic [W-1:0] ONE     = W'(1);

   generate
      if (MOD < 2 || MOD > (1 << W)) begin : g_bad_mod
         $error("down_counter_load: MOD must satisfy 2 <= MOD <= 2**W");
      end
   endgenerate

   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic         tc_q, tc_d;
   logic         mode_q, mode_d;
   logic [W-1:0] clamped_val;

   assign clamped_val = (load_val > MAX_VAL) ? MAX_VAL : load_val;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         tc_q    <= 1'b0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tc_q    <= tc_d;
         mode_q  <= mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tc_d    = 1'b0;
      mode_d  = mode_q;
      if (load) begin
         cnt_d   = clamped_val;
         mode_d  = oneshot;
         state_d = (oneshot && clamped_val == '0) ? ST_DONE : ST_RUN;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (en) begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - ONE;
                     if (cnt_q == ONE) begin
                        tc_d = 1'b1;
                        // one-shot finishes on the same edge that raises tc
                        if (mode_q) begin
                           state_d = ST_DONE;
                        end
                     end
                  end else if (!mode_q) begin
                     cnt_d = MAX_VAL;
                  end
               end
            end
            default: begin
               cnt_d = cnt_q;
            end
         endcase
      end
   end

   assign out  = cnt_q;
   assign tc   = tc_q;
   assign zero = (cnt_q == '0);
   assign busy = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_counter_load.sv
// tb/tb_down_counter_load.sv - self-checking bench for down_counter_load with a behavioural model
module tb_down_counter_load;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic         clk;
   logic         rst;
   logic         en;
   logic         load;
   logic [W-1:0] load_val;
   logic         oneshot;
   logic [W-1:0] out;
   logic         tc;
   logic         zero;
   logic         busy;

   int checks;
   int failures;

   int m_out;
   bit m_tc;
   bit m_busy;
   bit m_mode;

   down_counter_load #(.W(W), .MOD(MOD)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .oneshot  (oneshot),
      .out      (out),
      .tc       (tc),
      .zero     (zero),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_out  = 0;
      m_tc   = 1'b0;
      m_busy = 1'b0;
      m_mode = 1'b0;
   endtask

   // Behavioural view: a timer holding a value, a running flag and a mode bit.
   task automatic model_edge(input bit ld, input int lv, input bit os, input bit e);
      int v;
      if (ld) begin
         v      = (lv > MOD - 1) ? MOD - 1 : lv;
         m_out  = v;
         m_mode = os;
         m_busy = !(os && v == 0);
         m_tc   = 1'b0;
      end else if (m_busy && e) begin
         if (m_out == 0) begin
            m_out = MOD - 1;
            m_tc  = 1'b0;
         end else begin
            m_out = m_out - 1;
            m_tc  = (m_out == 0);
            if (m_tc && m_mode) m_busy = 1'b0;
         end
      end else begin
         m_tc = 1'b0;
      end
   endtask

   // Drive inputs, take one clock edge, advance the model, settle 1 ns past the edge.
   task automatic cycle(input bit ld, input int lv, input bit os, input bit e);
      load     = ld;
      load_val = W'(lv);
      oneshot  = os;
      en       = e;
      @(posedge clk);
      if (rst) model_edge(ld, lv, os, e);
      else     model_reset();
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      cycle(0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; en = 1'b0; load = 1'b0; load_val = '0; oneshot = 1'b0;
      model_reset();
      #3;
      checks++;
      if (out !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
         failures++;
         $display("FAIL reset_state got out=%0d zero=%0b busy=%0b tc=%0b exp out=0 zero=1 busy=0 tc=0", out, zero, busy, tc);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_idle_en();
      do_reset();
      for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1);
      checks++;
      if (out !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
         failures++;
         $display("FAIL idle_en got out=%0d busy=%0b tc=%0b exp out=0 busy=0 tc=0", out, busy, tc);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cycle(1, 7, 0, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 0, 1);
      checks++;
      if (out !== 4'd5) begin
         failures++;
         $display("FAIL async_pre got out=%0d exp=5", out);
      end
      #2 rst = 1'b0;
      model_reset();
      #1;
      checks++;
      if (out !== 4'd0 || zero !== 1'b1 || busy !== 1'b0 || tc !== 1'b0) begin
         failures++;
         $display("FAIL async_clear got out=%0d zero=%0b busy=%0b tc=%0b exp out=0 zero=1 busy=0 tc=0", out, zero, busy, tc);
      end
      for (int i = 0; i < 3; i++) cycle(1, 6, 0, 1);
      checks++;
      if (out !== 4'd0 || busy !== 1'b0 || zero !== 1'b1) begin
         failures++;
         $display("FAIL async_hold got out=%0d busy=%0b zero=%0b exp out=0 busy=0 zero=1", out, busy, zero);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_periodic_wrap();
      int exp_seq[14] = '{2, 1, 0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
      do_reset();
      cycle(1, 3, 0, 0);
      checks++;
      if (out !== 4'd3 || busy !== 1'b1 || tc !== 1'b0) begin
         failures++;
         $display("FAIL wrap_load got out=%0d busy=%0b tc=%0b exp out=3 busy=1 tc=0", out, busy, tc);
      end
      for (int i = 0; i < 14; i++) begin
         cycle(0, 0, 0, 1);
         checks++;
         if (out !== W'(exp_seq[i]) || tc !== (exp_seq[i] == 0) || busy !== 1'b1 || zero !== (exp_seq[i] == 0)) begin
            failures++;
            $display("FAIL wrap_step[%0d] got out=%0d tc=%0b busy=%0b zero=%0b exp out=%0d tc=%0b busy=1 zero=%0b",
                     i, out, tc, busy, zero, exp_seq[i], exp_seq[i] == 0, exp_seq[i] == 0);
         end
      end
   endtask

   task automatic test_oneshot();
      do_reset();
      cycle(1, 2, 1, 0);
      cycle(0, 0, 0, 1);
      checks++;
      if (out !== 4'd1 || tc !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL oneshot_1 got out=%0d tc=%0b busy=%0b exp out=1 tc=0 busy=1", out, tc, busy);
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (out !== 4'd0 || tc !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL oneshot_0 got out=%0d tc=%0b busy=%0b exp out=0 tc=1 busy=0", out, tc, busy);
      end
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 0, 1);
         checks++;
         if (out !== 4'd0 || tc !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_done[%0d] got out=%0d tc=%0b busy=%0b exp out=0 tc=0 busy=0", i, out, tc, busy);
         end
      end
   endtask

   task automatic test_clamp_priority();
      do_reset();
      cycle(1, 14, 0, 0);
      checks++;
      if (out !== 4'd9) begin
         failures++;
         $display("FAIL clamp got out=%0d exp=9", out);
      end
      for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
      checks++;
      if (out !== 4'd5) begin
         failures++;
         $display("FAIL clamp_count got out=%0d exp=5", out);
      end
      cycle(1, 7, 0, 1);
      checks++;
      if (out !== 4'd7 || tc !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL load_priority got out=%0d tc=%0b busy=%0b exp out=7 tc=0 busy=1", out, tc, busy);
      end
   endtask

   task automatic test_enable_gaps();
      bit en_pat[7]  = '{1, 0, 0, 1, 1, 0, 1};
      int exp_out[7] = '{3, 3, 3, 2, 1, 1, 0};
      do_reset();
      cycle(1, 4, 0, 0);
      for (int i = 0; i < 7; i++) begin
         cycle(0, 0, 0, en_pat[i]);
         checks++;
         if (out !== W'(exp_out[i]) || tc !== (i == 6)) begin
            failures++;
            $display("FAIL gaps[%0d] got out=%0d tc=%0b exp out=%0d tc=%0b", i, out, tc, exp_out[i], i == 6);
         end
      end
   endtask

   task automatic test_zero_load();
      do_reset();
      cycle(1, 0, 1, 1);
      checks++;
      if (out !== 4'd0 || busy !== 1'b0 || tc !== 1'b0) begin
         failures++;
         $display("FAIL zero_oneshot got out=%0d busy=%0b tc=%0b exp out=0 busy=0 tc=0", out, busy, tc);
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (out !== 4'd0 || tc !== 1'b0) begin
         failures++;
         $display("FAIL zero_oneshot_hold got out=%0d tc=%0b exp out=0 tc=0", out, tc);
      end
      cycle(1, 0, 0, 0);
      checks++;
      if (out !== 4'd0 || busy !== 1'b1 || zero !== 1'b1) begin
         failures++;
         $display("FAIL zero_periodic got out=%0d busy=%0b zero=%0b exp out=0 busy=1 zero=1", out, busy, zero);
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (out !== 4'd9 || tc !== 1'b0) begin
         failures++;
         $display("FAIL zero_periodic_wrap got out=%0d tc=%0b exp out=9 tc=0", out, tc);
      end
   endtask

   task automatic test_random();
      bit ld, os, e;
      int lv;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         ld = ($urandom_range(0, 9) == 0);
         lv = $urandom_range(0, 15);
         os = $urandom_range(0, 1);
         e  = ($urandom_range(0, 3) != 0);
         cycle(ld, lv, os, e);
         checks++;
         if (out !== W'(m_out) || tc !== m_tc || busy !== m_busy || zero !== (m_out == 0)) begin
            failures++;
            $display("FAIL random[%0d] got out=%0d tc=%0b busy=%0b zero=%0b exp out=%0d tc=%0b busy=%0b zero=%0b",
                     i, out, tc, busy, zero, m_out, m_tc, m_busy, m_out == 0);
         end
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_idle_en();
      test_async_reset();
      test_periodic_wrap();
      test_oneshot();
      test_clamp_priority();
      test_enable_gaps();
      test_zero_load();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
